mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency word memory between the CPU instruction-fetch port and the CPU load/store port.
- Sits between the CPU (PC/instruction side and dataAddress/MemRead/MemWrite side) and the unified memory model.
- Lets the CPU run against one physical memory by stalling on per-port ack.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_lat_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and limits for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    localparam int MEM_LAT_MAX = 15;
    localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// rtl/arb_lat_counter.sv - loadable down-counter with zero flag, times the memory read latency.
import mem_arb_pkg::*;

module arb_lat_counter (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [LAT_CNT_W-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_zero
);

    logic [LAT_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between the fetch and load/store ports.
// Optional statistics counters are built when ARB_STATS_EN is defined.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_if_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_if_stall
`endif
);

    localparam int LAT_EFF = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                             ((MEM_LAT < 1) ? 1 : MEM_LAT);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT_EFF - 1);
    localparam logic [ADDR_W-1:0]    WORD_MASK = ~ADDR_W'(3);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_owner_t        r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_err;

    logic              w_d_misaligned;
    logic              w_cnt_zero;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_resp;

    assign w_d_misaligned = is_misaligned(d_addr[1:0]);
    assign w_cnt_load     = (r_state == ISSUE);
    assign w_cnt_dec      = (r_state == WAIT);

    arb_lat_counter u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Data wins over fetch: the pending load/store belongs to the instruction already fetched.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (d_req) begin
                    w_next_state = w_d_misaligned ? RESP : ISSUE;
                end else if (if_req) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (w_cnt_zero) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= OWN_FETCH;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_d_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (d_req) begin
                        r_owner <= OWN_DATA;
                        r_addr  <= d_addr & WORD_MASK;
                        r_we    <= d_we & ~w_d_misaligned;
                        r_wdata <= d_wdata;
                        r_d_err <= w_d_misaligned;
                        if (w_d_misaligned) begin
                            r_d_rdata <= '0;
                        end
                    end else if (if_req) begin
                        r_owner <= OWN_FETCH;
                        r_addr  <= if_addr & WORD_MASK;
                        r_we    <= 1'b0;
                        r_d_err <= 1'b0;
                    end
                end
                WAIT: begin
                    if (w_cnt_zero && !r_we) begin
                        if (r_owner == OWN_FETCH) begin
                            r_if_rdata <= mem_rdata;
                        end else begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by reset so an abandoned access drops off the bus in the reset cycle itself.
    assign w_resp    = (r_state == RESP) && !reset;
    assign mem_en    = (r_state == ISSUE) && !reset;
    assign mem_we    = mem_en && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = w_resp && (r_owner == OWN_FETCH);
    assign d_ack     = w_resp && (r_owner == OWN_DATA);
    assign d_err     = d_ack && r_d_err;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_if_grants;
    logic [31:0] r_stat_d_grants;
    logic [31:0] r_stat_if_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_if_grants <= '0;
            r_stat_d_grants  <= '0;
            r_stat_if_stall  <= '0;
        end else begin
            if ((r_state == IDLE) && d_req) begin
                r_stat_d_grants <= r_stat_d_grants + 32'd1;
            end else if ((r_state == IDLE) && if_req) begin
                r_stat_if_grants <= r_stat_if_grants + 32'd1;
            end
            if (if_req && !if_ack) begin
                r_stat_if_stall <= r_stat_if_stall + 32'd1;
            end
        end
    end

    assign stat_if_grants = r_stat_if_grants;
    assign stat_d_grants  = r_stat_d_grants;
    assign stat_if_stall  = r_stat_if_stall;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-schedule model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [31:0] stat_if_grants;
    logic [31:0] stat_d_grants;
    logic [31:0] stat_if_stall;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_d_grants  (stat_d_grants),
        .stat_if_stall  (stat_if_stall)
`endif
    );

    always #5 clk = ~clk;

    int ntot = 0;
    int nbad = 0;
    int cyc  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2008_0005;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory device: words written so far override the initial pattern.
    bit          dev_wr  [16384];
    logic [31:0] dev_mem [16384];
    bit          pv [LAT];
    logic [31:0] pd [LAT];

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        return dev_wr[a[15:2]] ? dev_mem[a[15:2]] : init_word({a[31:2], 2'b00});
    endfunction

    always @(posedge clk) begin
        pv[0] <= mem_en && !mem_we;
        pd[0] <= dev_read(mem_addr);
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
        if (mem_en && mem_we) begin
            dev_wr[mem_addr[15:2]]  <= 1'b1;
            dev_mem[mem_addr[15:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;

    // Model: one transaction at a time; a grant at cycle g strobes memory at g+1 and acks at
    // g+LAT+2 (misaligned data: no strobe, ack at g+1); the arbiter is free again the cycle after.
    bit          mdl_wr  [16384];
    logic [31:0] mdl_mem [16384];
    bit          m_active = 0;
    bit          m_own_d, m_we, m_mis, post_reset;
    logic [31:0] m_addr, m_wd;
    int          t_men, t_ack;
    logic [31:0] e_if_rd = '0;
    logic [31:0] e_d_rd  = '0;
    bit          e_men, e_ifack, e_dack, e_err;
    int          men_q[$];
    logic [31:0] madr_q[$];
    logic [31:0] mwd_q[$];
    logic        mwe_q[$];
    int          ifack_seen = 0;

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        return mdl_wr[a[15:2]] ? mdl_mem[a[15:2]] : init_word(a);
    endfunction

    initial forever begin
        @(negedge clk);
        e_men = 0; e_ifack = 0; e_dack = 0; e_err = 0;
        if (mem_en) begin
            men_q.push_back(cyc);
            madr_q.push_back(mem_addr);
            mwd_q.push_back(mem_wdata);
            mwe_q.push_back(mem_we);
        end
        if (if_ack) ifack_seen++;
        if (reset) begin
            m_active = 0;
            e_if_rd = '0;
            e_d_rd = '0;
            post_reset = 1;
            chk("mem_en_in_reset", 32'(mem_en), 32'd0);
            chk("if_ack_in_reset", 32'(if_ack), 32'd0);
            chk("d_ack_in_reset", 32'(d_ack), 32'd0);
            chk("d_err_in_reset", 32'(d_err), 32'd0);
        end else begin
            if (m_active) begin
                if (cyc == t_men) e_men = 1;
                if (cyc == t_ack) begin
                    if (m_own_d) begin
                        e_dack = 1;
                        e_err = m_mis;
                        if (m_mis) e_d_rd = '0;
                        else if (!m_we) e_d_rd = mdl_read(m_addr);
                    end else begin
                        e_ifack = 1;
                        e_if_rd = mdl_read(m_addr);
                    end
                    m_active = 0;
                end
            end else if (d_req || if_req) begin
                m_active = 1;
                m_own_d = d_req;
                m_addr = (d_req ? d_addr : if_addr) & ~32'd3;
                m_we = d_req && d_we;
                m_wd = d_wdata;
                m_mis = d_req && (d_addr[1:0] != 2'b00);
                if (m_mis) begin
                    t_men = -1;
                    t_ack = cyc + 1;
                end else begin
                    t_men = cyc + 1;
                    t_ack = cyc + LAT + 2;
                    if (m_we) begin
                        mdl_wr[m_addr[15:2]] = 1'b1;
                        mdl_mem[m_addr[15:2]] = m_wd;
                    end
                end
            end
            chk("mem_en", 32'(mem_en), 32'(e_men));
            chk("if_ack", 32'(if_ack), 32'(e_ifack));
            chk("d_ack", 32'(d_ack), 32'(e_dack));
            chk("if_rdata", if_rdata, e_if_rd);
            chk("d_rdata", d_rdata, e_d_rd);
            if (e_men) begin
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_addr", mem_addr, m_addr);
                if (m_we) chk("mem_wdata", mem_wdata, m_wd);
            end
            if (e_dack) chk("d_err", 32'(d_err), 32'(e_err));
            if (post_reset) begin
                chk("mem_addr_after_reset", mem_addr, 32'd0);
                chk("mem_wdata_after_reset", mem_wdata, 32'd0);
                post_reset = 0;
            end
        end
    end

    int s, ti, td;
    logic [31:0] got_d_rdata;
    logic        got_d_err;

    task automatic run(input bit do_if, input logic [31:0] ia, input bit do_d, input bit we,
                       input logic [31:0] da, input logic [31:0] wd,
                       output int st, output int t_if, output int t_d);
        bit pend_if, pend_d, drop_if, drop_d;
        @(posedge clk); #1;
        men_q.delete(); madr_q.delete(); mwd_q.delete(); mwe_q.delete();
        st = cyc; t_if = -1; t_d = -1;
        if (do_if) begin if_req = 1'b1; if_addr = ia; end
        if (do_d) begin d_req = 1'b1; d_we = we; d_addr = da; d_wdata = wd; end
        pend_if = do_if; pend_d = do_d;
        for (int k = 0; k < 40 && (pend_if || pend_d); k++) begin
            @(negedge clk);
            drop_if = pend_if && if_ack;
            drop_d = pend_d && d_ack;
            if (drop_if) begin t_if = cyc - st; pend_if = 0; end
            if (drop_d) begin
                t_d = cyc - st; pend_d = 0;
                got_d_rdata = d_rdata; got_d_err = d_err;
            end
            @(posedge clk); #1;
            if (drop_if) if_req = 1'b0;
            if (drop_d) d_req = 1'b0;
        end
        chk("ack_timeout", {30'd0, pend_if, pend_d}, 32'd0);
        if_req = 1'b0;
        d_req = 1'b0;
    endtask

    function automatic int men_rel(input int i, input int st);
        return (men_q.size() > i) ? men_q[i] - st : -1;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);

        // Fetch alone
        run(1, 32'h3000, 0, 0, 0, 0, s, ti, td);
        chk("s1_men_cyc", 32'(men_rel(0, s)), 32'd1);
        chk("s1_men_addr", madr_q.size() > 0 ? madr_q[0] : 32'hFFFF_FFFF, 32'h3000);
        chk("s1_ack_cyc", 32'(ti), 32'd4);
        chk("s1_if_rdata", if_rdata, 32'h2008_0005);

        // Simultaneous fetch and load: data first
        run(1, 32'h3004, 1, 0, 32'h0010, 0, s, ti, td);
        chk("s2_d_ack_cyc", 32'(td), 32'd4);
        chk("s2_d_rdata", got_d_rdata, 32'hC0DE_0010);
        chk("s2_men_n", 32'(men_q.size()), 32'd2);
        chk("s2_men0_cyc", 32'(men_rel(0, s)), 32'd1);
        chk("s2_men0_addr", madr_q.size() > 0 ? madr_q[0] : 32'hFFFF_FFFF, 32'h0010);
        chk("s2_men1_cyc", 32'(men_rel(1, s)), 32'd6);
        chk("s2_men1_addr", madr_q.size() > 1 ? madr_q[1] : 32'hFFFF_FFFF, 32'h3004);
        chk("s2_if_ack_cyc", 32'(ti), 32'd9);
        chk("s2_if_rdata", if_rdata, 32'hC0DE_3004);

        // Store
        run(0, 0, 1, 1, 32'h0020, 32'hDEAD_BEEF, s, ti, td);
        chk("s3_men_n", 32'(men_q.size()), 32'd1);
        chk("s3_men_we", men_q.size() > 0 ? 32'(mwe_q[0]) : 32'hFFFF_FFFF, 32'd1);
        chk("s3_men_addr", madr_q.size() > 0 ? madr_q[0] : 32'hFFFF_FFFF, 32'h0020);
        chk("s3_men_wdata", mwd_q.size() > 0 ? mwd_q[0] : 32'h0, 32'hDEAD_BEEF);
        chk("s3_d_ack_cyc", 32'(td), 32'd4);
        chk("s3_d_err", 32'(got_d_err), 32'd0);
        run(0, 0, 1, 0, 32'h0020, 0, s, ti, td);
        chk("s3_readback", got_d_rdata, 32'hDEAD_BEEF);

        // Misaligned load and store
        run(0, 0, 1, 0, 32'h0022, 0, s, ti, td);
        chk("s4_men_n", 32'(men_q.size()), 32'd0);
        chk("s4_d_ack_cyc", 32'(td), 32'd1);
        chk("s4_d_err", 32'(got_d_err), 32'd1);
        chk("s4_d_rdata", got_d_rdata, 32'd0);
        run(0, 0, 1, 1, 32'h0021, 32'h1234_5678, s, ti, td);
        chk("s4b_men_n", 32'(men_q.size()), 32'd0);
        chk("s4b_d_err", 32'(got_d_err), 32'd1);

        // Fetch address low bits are ignored
        run(1, 32'h300A, 0, 0, 0, 0, s, ti, td);
        chk("s6_men_addr", madr_q.size() > 0 ? madr_q[0] : 32'hFFFF_FFFF, 32'h3008);
        chk("s6_if_rdata", if_rdata, 32'hC0DE_3008);

        // Reset during WAIT abandons the fetch
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h3004;
        s = ifack_seen;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk("s5_if_rdata_zero", if_rdata, 32'd0);
        chk("s5_mem_addr_zero", mem_addr, 32'd0);
        repeat (8) @(negedge clk);
        chk("s5_no_ack", 32'(ifack_seen - s), 32'd0);
        run(1, 32'h3000, 0, 0, 0, 0, s, ti, td);
        chk("s5_fresh_ack_cyc", 32'(ti), 32'd4);
        chk("s5_fresh_rdata", if_rdata, 32'h2008_0005);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
